// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default line parameters,
// kept in one place so the future transmitter agrees with the receiver.
package uart_pkg;

  localparam int UART_CLK_FREQ = 50_000_000;
  localparam int UART_BAUD     = 115_200;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rxState_e;

  // Integer clocks per bit; fractional baud error is absorbed by mid-bit sampling.
  function automatic int clksPerBit(input int clkFreq, input int baud);
    return clkFreq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous, idle-high input.
// Both stages reset to 1 so a line held in reset never looks like a start bit.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver: oversamples the synchronised line, samples each bit at its
// centre, and presents good bytes with a one-cycle uart_end strobe.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = UART_CLK_FREQ,
  parameter int BAUD         = UART_BAUD,
  parameter int CLKS_PER_BIT = clksPerBit(CLK_FREQ, BAUD),
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] uart_data,
  output logic       uart_end,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic             rxSync;
  rxState_e         state_q,    state_d;
  logic [CNT_W-1:0] baudCnt_q,  baudCnt_d;
  logic [2:0]       bitCnt_q,   bitCnt_d;
  logic [7:0]       shift_q,    shift_d;
  logic [7:0]       data_q,     data_d;
  logic             uartEnd_q,  uartEnd_d;
  logic             frameErr_q, frameErr_d;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rx),
    .q_o   (rxSync)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      baudCnt_q  <= '0;
      bitCnt_q   <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      uartEnd_q  <= 1'b0;
      frameErr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baudCnt_q  <= baudCnt_d;
      bitCnt_q   <= bitCnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      uartEnd_q  <= uartEnd_d;
      frameErr_q <= frameErr_d;
    end
  end

  // The baud counter free-runs within a state and restarts on every transition,
  // so each state's sample point is a fixed offset from its entry.
  always_comb begin
    state_d    = state_q;
    baudCnt_d  = (baudCnt_q == BIT_LAST) ? '0 : baudCnt_q + CNT_W'(1);
    bitCnt_d   = bitCnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    uartEnd_d  = 1'b0;
    frameErr_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rxSync) begin
          state_d = START;
        end
      end

      START: begin
        if (baudCnt_q == HALF_LAST) begin
          if (!rxSync) begin
            state_d  = DATA;
            bitCnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end

      DATA: begin
        if (baudCnt_q == BIT_LAST) begin
          shift_d  = {rxSync, shift_q[7:1]};
          bitCnt_d = bitCnt_q + 3'd1;
          if (bitCnt_q == 3'd7) begin
            state_d = STOP;
          end
        end
      end

      STOP: begin
        if (baudCnt_q == BIT_LAST) begin
          if (rxSync) begin
            data_d    = shift_q;
            uartEnd_d = 1'b1;
            state_d   = IDLE;
          end else begin
            frameErr_d = 1'b1;
            state_d    = BREAK;
          end
        end
      end

      BREAK: begin
        if (rxSync) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d != state_q) begin
      baudCnt_d = '0;
    end
  end

  assign uart_data = data_q;
  assign uart_end  = uartEnd_q;
  assign frame_err = frameErr_q;
  assign rx_busy   = (state_q != IDLE);

  // Structural invariants the capture stage relies on.
  strobesExclusive: assert property (@(posedge clk) disable iff (!rst_n)
    !(uartEnd_q && frameErr_q));

  endIsSingleCycle: assert property (@(posedge clk) disable iff (!rst_n)
    uartEnd_q |=> !uartEnd_q);

  errIsSingleCycle: assert property (@(posedge clk) disable iff (!rst_n)
    frameErr_q |=> !frameErr_q);

  baudCntInRange: assert property (@(posedge clk) disable iff (!rst_n)
    baudCnt_q <= BIT_LAST);

  stateLegal: assert property (@(posedge clk) disable iff (!rst_n)
    state_q inside {IDLE, START, DATA, STOP, BREAK});

  dataHeldBetweenEnds: assert property (@(posedge clk) disable iff (!rst_n)
    !uartEnd_d |=> (data_q == $past(data_q)));

endmodule

// File: tb/tb_uart_byte_rx.sv
// Self-checking bench for uart_byte_rx: fixed vector table, hand-written corner
// sequences, then random frames against a frame-level reference model.
module tb_uart_byte_rx;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int CPB      = 10;
  localparam int HALF     = 5;
  localparam int LATENCY  = 1 + 2 + HALF + 9 * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] uart_data;
  logic       uart_end;
  logic       frame_err;
  logic       rx_busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int         cyc;
    bit         isEnd;
    bit         isErr;
    logic [7:0] data;
  } event_t;

  typedef struct {
    logic [7:0] txByte;
    bit         stopHigh;
    int         lowHold;
    int         gap;
    bit         expEnd;
    bit         expErr;
    logic [7:0] expData;
  } vec_t;

  event_t     evQ[$];
  vec_t       vecs[8];
  logic [7:0] modelData;

  uart_byte_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .uart_data (uart_data),
    .uart_end  (uart_end),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every strobe is logged with the cycle it was seen in.
  always @(negedge clk) begin
    if (rst_n && (uart_end || frame_err)) begin
      evQ.push_back('{cyc, uart_end, frame_err, uart_data});
    end
  end

  initial begin
    #500_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic driveLevel(input logic lvl, input int n);
    for (int i = 0; i < n; i++) begin
      rx = lvl;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sendFrame(input logic [7:0] b, input bit stopHigh, output int fallCyc);
    fallCyc = cyc;
    driveLevel(1'b0, CPB);
    for (int k = 0; k < 8; k++) begin
      driveLevel(b[k], CPB);
    end
    driveLevel(stopHigh, CPB);
  endtask

  // Extra low time after the stop bit (a break), then idle-high gap.
  task automatic idleLine(input string tag, input int lowHold, input int gap);
    int notBusy;
    notBusy = 0;
    if (lowHold > 0) begin
      for (int i = 0; i < lowHold; i++) begin
        rx = 1'b0;
        @(posedge clk);
        #1;
        if (!rx_busy) notBusy++;
      end
      check({tag, ".busyDuringBreak"}, 32'(notBusy), 32'd0);
    end
    if (lowHold > 0 && gap >= 4) begin
      driveLevel(1'b1, 4);
      check({tag, ".busyAfterBreak"}, 32'(rx_busy), 32'd0);
      driveLevel(1'b1, gap - 4);
    end else begin
      driveLevel(1'b1, gap);
    end
  endtask

  task automatic checkOutput(input string tag, input bit expEnd, input bit expErr,
                             input logic [7:0] expData, input int expCyc);
    event_t ev;
    check({tag, ".eventCount"}, 32'(evQ.size()), 32'd1);
    if (evQ.size() > 0) begin
      ev = evQ.pop_front();
      check({tag, ".uartEnd"}, 32'(ev.isEnd), 32'(expEnd));
      check({tag, ".frameErr"}, 32'(ev.isErr), 32'(expErr));
      check({tag, ".eventCycle"}, 32'(ev.cyc), 32'(expCyc));
      if (expEnd) check({tag, ".strobeData"}, 32'(ev.data), 32'(expData));
    end
    check({tag, ".heldData"}, 32'(uart_data), 32'(expData));
    evQ.delete();
  endtask

  task automatic applyStimulus(input string tag, input vec_t v);
    int fallCyc;
    sendFrame(v.txByte, v.stopHigh, fallCyc);
    checkOutput(tag, v.expEnd, v.expErr, v.expData, fallCyc + LATENCY);
    idleLine(tag, v.lowHold, v.gap);
  endtask

  initial begin
    int     glitchBusy;
    int     fallCyc;
    vec_t   rv;

    vecs[0] = '{8'hA5, 1'b1,  0, 20, 1'b1, 1'b0, 8'hA5};
    vecs[1] = '{8'h00, 1'b1,  0,  0, 1'b1, 1'b0, 8'h00};
    vecs[2] = '{8'hFF, 1'b1,  0, 20, 1'b1, 1'b0, 8'hFF};
    vecs[3] = '{8'h11, 1'b1,  0, 10, 1'b1, 1'b0, 8'h11};
    vecs[4] = '{8'h3C, 1'b0, 30, 20, 1'b0, 1'b1, 8'h11};
    vecs[5] = '{8'h5A, 1'b1,  0, 15, 1'b1, 1'b0, 8'h5A};
    vecs[6] = '{8'h80, 1'b0,  0, 15, 1'b0, 1'b1, 8'h5A};
    vecs[7] = '{8'h01, 1'b1,  0, 15, 1'b1, 1'b0, 8'h01};

    // Reset values, held in reset with the line idle.
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset.uartData", 32'(uart_data), 32'h00);
    check("reset.uartEnd", 32'(uart_end), 32'd0);
    check("reset.frameErr", 32'(frame_err), 32'd0);
    check("reset.rxBusy", 32'(rx_busy), 32'd0);
    rst_n = 1'b1;
    driveLevel(1'b1, 20);
    check("idle.rxBusy", 32'(rx_busy), 32'd0);
    check("idle.noEvents", 32'(evQ.size()), 32'd0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i]);
    end

    // Three-clock glitch: START is abandoned at the half-bit check.
    glitchBusy = 0;
    for (int i = 0; i < 20; i++) begin
      rx = (i < 3) ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
      if (rx_busy) glitchBusy++;
    end
    check("glitch.busyCycles", 32'(glitchBusy), 32'd5);
    check("glitch.busyEnd", 32'(rx_busy), 32'd0);
    check("glitch.noEvents", 32'(evQ.size()), 32'd0);
    check("glitch.heldData", 32'(uart_data), 32'h01);
    evQ.delete();

    // Reset in the middle of data bit 3 of 0xC3.
    driveLevel(1'b0, CPB);
    driveLevel(1'b1, CPB);
    driveLevel(1'b1, CPB);
    driveLevel(1'b0, CPB);
    driveLevel(1'b0, 5);
    check("midReset.busyBefore", 32'(rx_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midReset.uartData", 32'(uart_data), 32'h00);
    check("midReset.uartEnd", 32'(uart_end), 32'd0);
    check("midReset.frameErr", 32'(frame_err), 32'd0);
    check("midReset.rxBusy", 32'(rx_busy), 32'd0);
    rx = 1'b1;
    @(posedge clk);
    #1;
    driveLevel(1'b1, 3);
    rst_n = 1'b1;
    driveLevel(1'b1, 10);
    evQ.delete();
    sendFrame(8'h7E, 1'b1, fallCyc);
    checkOutput("afterReset", 1'b1, 1'b0, 8'h7E, fallCyc + LATENCY);
    driveLevel(1'b1, 10);
    modelData = 8'h7E;

    // Random frames: a good stop bit delivers the byte, a low one keeps the old byte.
    for (int i = 0; i < 40; i++) begin
      rv.txByte   = 8'($urandom);
      rv.stopHigh = ($urandom_range(0, 3) != 0);
      rv.lowHold  = rv.stopHigh ? 0 : int'($urandom_range(0, 25));
      rv.gap      = rv.stopHigh ? int'($urandom_range(0, 12)) : int'($urandom_range(3, 15));
      if (rv.stopHigh) begin
        modelData = rv.txByte;
      end
      rv.expEnd  = rv.stopHigh;
      rv.expErr  = !rv.stopHigh;
      rv.expData = modelData;
      applyStimulus($sformatf("rand%0d", i), rv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_byte_rx.md
# uart_byte_rx

Serial receive front end for the logic-analyser capture path. It oversamples the asynchronous `rx` pin with the system clock and deframes 8N1 characters (1 start bit, 8 data bits LSB first, 1 stop bit). Each good byte is presented on `uart_data` with a one-cycle `uart_end` strobe. It feeds the frame/RAM-write stage directly: that stage edge-detects `uart_end` and writes `uart_data` into capture RAM.

## Interface
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `BAUD`, default 115200: line rate in bit/s.
- `CLKS_PER_BIT`, default `CLK_FREQ/BAUD` (integer division; 434 at defaults): clocks per bit. Must be ≥ 4.
- `HALF_BIT`, default `CLKS_PER_BIT/2` (217 at defaults): clocks to mid-start-bit.
- `clk` in 1: system clock. This is the single clock; all logic is on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `rx` in 1: asynchronous serial line, idle high.
- `uart_data` out 8: last good received byte.
- `uart_end` out 1: one-cycle strobe when a good byte completes.
- `frame_err` out 1: one-cycle strobe when the stop bit is sampled low.
- `rx_busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- **Synchroniser:** `rx` passes through 2 flops, both reset to 1, producing `rx_s`. All decisions use `rx_s` only.
- **Counters:**
  - Baud counter is `$clog2(CLKS_PER_BIT)` bits wide. It counts 0..CLKS_PER_BIT-1 and clears on every state change.
  - Bit counter is 3 bits wide.
- **FSM states:** IDLE, START, DATA, STOP, BREAK.
  - IDLE: if `rx_s`==0, go to START.
  - START: at count HALF_BIT-1, if `rx_s`==0 go to DATA; otherwise go to IDLE (glitch, no output).
  - DATA: at count CLKS_PER_BIT-1, shift `rx_s` into the MSB of the shift register (LSB arrives first). After 8 bits, go to STOP.
  - STOP: at count CLKS_PER_BIT-1:
    - If `rx_s`==1: load `uart_data` from the shift register, pulse `uart_end`, go to IDLE.
    - Otherwise: pulse `frame_err`, leave `uart_data` unchanged, go to BREAK.
  - BREAK: stay until `rx_s`==1, then go to IDLE.
- `uart_end` and `frame_err` are never high in the same cycle.
- `uart_data` holds its value from a `uart_end` cycle until the next `uart_end`.
- **Reset:** asserting `rst_n` at any time, including mid-character, immediately forces:
  - state to IDLE;
  - `uart_data` to 0x00;
  - `uart_end`, `frame_err`, `rx_busy` to 0;
  - shift register and both counters to 0;
  - both synchroniser flops to 1.

## Timing
- Let t0 be the first cycle in START.
- Sample points:
  - Start-bit check at t0+HALF_BIT.
  - Data bit k (k = 0..7) at t0+HALF_BIT+(k+1)·CLKS_PER_BIT.
  - Stop bit at t0+HALF_BIT+9·CLKS_PER_BIT.
- `uart_end` or `frame_err` is registered high for exactly one cycle, in the cycle after the stop sample.
- `rx` to `rx_s` latency is 2 clocks. Total latency from the `rx` falling edge to `uart_end` is 2+1+HALF_BIT+9·CLKS_PER_BIT clocks.
- Back-to-back characters (next start bit immediately after a one-bit stop) must be received without loss. After the stop sample, IDLE is re-entered with ≥ HALF_BIT-2 clocks of margin.
- `rx_busy` rises in the cycle the FSM enters START and falls in the cycle it enters IDLE.

## Structure
- Shared package `uart_pkg` holds:
  - the FSM state encoding (IDLE=0, START=1, DATA=2, STOP=3, BREAK=4, 3-bit);
  - default `CLK_FREQ` and `BAUD` constants, shared with the future transmitter.
- One sub-module: `uart_rx_sync`, a 2-flop synchroniser with reset value 1. It is reused by other asynchronous inputs.
- The remainder is a single FSM/datapath process set in `uart_byte_rx`. No memories.

## Test plan
Bench uses CLK_FREQ=1_000_000, BAUD=100_000, giving CLKS_PER_BIT=10 and HALF_BIT=5.
- **Single byte:** send 0xA5. Expect exactly one `uart_end` pulse 1+2+5+90 clocks after the `rx` fall, `uart_data`=0xA5, `frame_err` never high.
- **Back-to-back:** send 0x00 then 0xFF with no idle gap. Expect two `uart_end` pulses 100 clocks apart, with data 0x00 then 0xFF.
- **Glitch:** drive `rx` low for 3 clocks, then high. Expect no `uart_end` or `frame_err`. `rx_busy` is high for 5 clocks, then 0.
- **Framing error:** after 0x11 is received, send 0x3C with the stop bit low, then hold `rx` low for 30 clocks. Expect:
  - one `frame_err` pulse and no `uart_end`;
  - `uart_data` stays 0x11;
  - `rx_busy` stays high until `rx` returns high;
  - a following 0x5A is received correctly.
- **Reset mid-character:** assert `rst_n` low during DATA bit 3 of 0xC3. Expect all outputs 0 in the same cycle. After release with `rx` idle, 0x7E is received correctly.
